// File: rtl/cpu_ctrl_pkg.sv
// Purpose: shared CPU-controller types and constants used by the program
//          counter and the fetch/decode logic.
// Contents: PC_WIDTH, PC_RESET, pc_t.
package cpu_ctrl_pkg;

  localparam int unsigned PC_WIDTH = 3;
  localparam int unsigned PC_RESET = 0;

  typedef logic [PC_WIDTH-1:0] pc_t;

endpackage

// File: rtl/pc_next_logic.sv
// Purpose: combinational next-count logic for the program counter.
//          Selects among the reset value, the wrap to zero, and the increment.
// Ports:
//   rstn    in   1      synchronous active-low reset, applied via the next value
//   cur     in   WIDTH  current registered count
//   next_c  out  WIDTH  value to load on the next rising clock edge
module pc_next_logic
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = PC_WIDTH,
  parameter int unsigned RESET_VAL = PC_RESET,
  parameter int unsigned WRAP_VAL  = (2 ** WIDTH) - 1
) (
  input  logic             rstn,
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] next_c
);

  // The >= compare pulls any out-of-range count back to zero.
  always_comb begin
    next_c = cur;
    if (!rstn) begin
      next_c = WIDTH'(RESET_VAL);
    end else if (cur >= WIDTH'(WRAP_VAL)) begin
      next_c = '0;
    end else begin
      next_c = cur + WIDTH'(1);
    end
  end

endmodule

// File: rtl/program_counter.sv
// Purpose: free-running instruction-address counter. Advances by one on
//          every rising edge out of reset and wraps to zero after WRAP_VAL.
// Ports:
//   clk   in   1      clock, all updates on the rising edge
//   rstn  in   1      synchronous active-low reset, loads RESET_VAL
//   out   out  WIDTH  current count, driven straight from the state register
module program_counter
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = PC_WIDTH,
  parameter int unsigned RESET_VAL = PC_RESET,
  parameter int unsigned WRAP_VAL  = (2 ** WIDTH) - 1
) (
  input  logic             clk,
  input  logic             rstn,
  output logic [WIDTH-1:0] out
);

  localparam longint unsigned MAX_VAL = (64'(1) << WIDTH) - 64'(1);

  // Reject parameter sets the counter cannot represent.
  if (WIDTH < 1) begin : g_bad_width
    $error("program_counter: WIDTH must be >= 1");
  end
  if (64'(WRAP_VAL) > MAX_VAL) begin : g_bad_wrap
    $error("program_counter: WRAP_VAL exceeds 2**WIDTH-1");
  end
  if (RESET_VAL > WRAP_VAL) begin : g_bad_reset
    $error("program_counter: RESET_VAL exceeds WRAP_VAL");
  end

  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;

  pc_next_logic #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL),
    .WRAP_VAL (WRAP_VAL)
  ) u_next (
    .rstn  (rstn),
    .cur   (out_q),
    .next_c(out_d)
  );

  // State register; rstn is sampled here through out_d, making reset synchronous.
  always_ff @(posedge clk) begin
    out_q <= out_d;
  end

  assign out = out_q;

`ifndef SYNTHESIS
  // Tracks whether a reset edge has been seen; the count is undefined before it.
  logic seen_rst_q;
  always_ff @(posedge clk) begin
    seen_rst_q <= seen_rst_q | !rstn;
  end

  a_in_range: assert property (@(posedge clk)
    (seen_rst_q === 1'b1) |-> (out_q <= WIDTH'(WRAP_VAL)));

  a_step: assert property (@(posedge clk)
    (($past(rstn) === 1'b1) && ($past(seen_rst_q) === 1'b1)) |->
      ((out_q == WIDTH'($past(out_q) + WIDTH'(1))) || (out_q == '0)));
`endif

endmodule

// File: tb/tb_program_counter.sv
// Purpose: directed bench for program_counter, default and WIDTH=4/WRAP=9/RESET=2.
// Expected values are queued as each step is driven and popped after the edge.
module tb_program_counter;
  import cpu_ctrl_pkg::*;

  localparam int unsigned PW    = 4;
  localparam int unsigned PRST  = 2;
  localparam int unsigned PWRAP = 9;

  logic          clk = 1'b0;
  logic          rstn;
  pc_t           out_a;
  logic [PW-1:0] out_b;

  int checks = 0;
  int errors = 0;
  int qa[$];
  int qb[$];
  int mb = 0;

  program_counter dut_a (
    .clk (clk),
    .rstn(rstn),
    .out (out_a)
  );

  program_counter #(
    .WIDTH    (PW),
    .RESET_VAL(PRST),
    .WRAP_VAL (PWRAP)
  ) dut_b (
    .clk (clk),
    .rstn(rstn),
    .out (out_b)
  );

  always #5 clk = ~clk;

  function automatic int model_b(input int cur, input logic r);
    if (!r) return PRST;
    if (cur >= PWRAP) return 0;
    return cur + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp))
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive rstn at the falling edge, queue expectations, compare 1 unit after the rising edge.
  task automatic step(input logic r, input int exp_a, input string tag);
    @(negedge clk);
    rstn = r;
    qa.push_back(exp_a);
    mb = model_b(mb, r);
    qb.push_back(mb);
    @(posedge clk);
    #1;
    check({tag, "_w3"}, 32'(out_a), qa.pop_front());
    check({tag, "_w4"}, 32'(out_b), qb.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0;

    step(1'b0, 0, "reset");

    for (int i = 1; i <= 5; i++) step(1'b1, i, "count");

    step(1'b1, 6, "wrap");
    step(1'b1, 7, "wrap");
    step(1'b1, 0, "wrap");
    step(1'b1, 1, "wrap");
    step(1'b1, 2, "wrap");

    step(1'b1, 3, "to5");
    step(1'b1, 4, "to5");
    step(1'b1, 5, "to5");
    step(1'b0, 0, "mid_reset");
    step(1'b1, 1, "release");

    for (int i = 0; i < 4; i++) step(1'b0, 0, "held_reset");
    step(1'b1, 1, "release_held");

    step(1'b0, 0, "param_reset");
    for (int i = 1; i <= 12; i++) step(1'b1, i % 8, "param_run");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
